// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline constants, fetch FSM states and PC helper
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          RS1_LSB   = 15;
    localparam int          RS2_LSB   = 20;
    localparam int          REG_W     = 5;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // Wraps modulo 2^32 by construction of the 32-bit sum.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush > stall > load > bubble priority
module if_id_reg
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr_d,
    output logic [31:0] o_pc_d,
    output logic [31:0] o_pc_plus4_d,
    output logic        o_valid_d
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    // Bubbles only clear instr/valid; pc fields keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= 32'd0;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_stall) begin
            r_instr <= r_instr;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= pc_plus4(i_pc);
            r_valid    <= 1'b1;
        end else begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end
    end

    assign o_instr_d    = r_instr;
    assign o_pc_d       = r_pc;
    assign o_pc_plus4_d = r_pc_plus4;
    assign o_valid_d    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, single-outstanding imem handshake, hold buffer, IF/ID
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_f,
    input  logic             stall_d,
    input  logic             flush_d,
    input  logic             pc_src_e,
    input  logic [31:0]      pc_target_e,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [31:0]      imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic [31:0]      instr_d,
    output logic [31:0]      pc_d,
    output logic [31:0]      pc_plus4_d,
    output logic             valid_d,
    output logic [REG_W-1:0] rs1_d,
    output logic [REG_W-1:0] rs2_d
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc_f;
    logic [31:0]  w_pc_f_nxt;
    logic [31:0]  r_req_pc;
    logic [31:0]  w_req_pc_nxt;
    logic         r_discard;
    logic         w_discard_nxt;
    logic [31:0]  r_buf_instr;
    logic         w_buf_we;
    logic         w_req_fire;
    logic         w_id_free;
    logic         w_load;
    logic [31:0]  w_load_instr;
    logic [31:0]  w_target;

    assign w_target       = pc_target_e & 32'hFFFF_FFFC;
    assign imem_req_valid = (r_state == REQ) && !stall_f && !rst;
    assign imem_addr      = r_pc_f;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_id_free      = !stall_d && !flush_d;

    // r_req_pc doubles as the buffered word's PC: it is unchanged in HOLD.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_f_nxt    = r_pc_f;
        w_req_pc_nxt  = r_req_pc;
        w_discard_nxt = r_discard;
        w_buf_we      = 1'b0;
        w_load        = 1'b0;
        w_load_instr  = imem_rsp_data;
        unique case (r_state)
            REQ: begin
                if (w_req_fire) begin
                    w_state_nxt   = WAIT;
                    w_req_pc_nxt  = r_pc_f;
                    w_discard_nxt = pc_src_e;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (r_discard || pc_src_e) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = REQ;
                    end else if (w_id_free) begin
                        w_load      = 1'b1;
                        w_pc_f_nxt  = pc_plus4(r_req_pc);
                        w_state_nxt = REQ;
                    end else begin
                        w_buf_we    = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end else if (pc_src_e) begin
                    w_discard_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (pc_src_e) begin
                    w_state_nxt = REQ;
                end else if (w_id_free) begin
                    w_load       = 1'b1;
                    w_load_instr = r_buf_instr;
                    w_pc_f_nxt   = pc_plus4(r_req_pc);
                    w_state_nxt  = REQ;
                end
            end
            default: w_state_nxt = REQ;
        endcase
        if (pc_src_e) begin
            w_pc_f_nxt = w_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= REQ;
            r_pc_f      <= RESET_PC;
            r_req_pc    <= RESET_PC;
            r_discard   <= 1'b0;
            r_buf_instr <= NOP_INSTR;
        end else begin
            r_state   <= w_state_nxt;
            r_pc_f    <= w_pc_f_nxt;
            r_req_pc  <= w_req_pc_nxt;
            r_discard <= w_discard_nxt;
            if (w_buf_we) begin
                r_buf_instr <= imem_rsp_data;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (flush_d),
        .i_stall      (stall_d),
        .i_load       (w_load),
        .i_instr      (w_load_instr),
        .i_pc         (r_req_pc),
        .o_instr_d    (instr_d),
        .o_pc_d       (pc_d),
        .o_pc_plus4_d (pc_plus4_d),
        .o_valid_d    (valid_d)
    );

    assign rs1_d = instr_d[RS1_LSB +: REG_W];
    assign rs2_d = instr_d[RS2_LSB +: REG_W];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;

    int err_cnt = 0;
    int chk_cnt = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .pc_src_e       (pc_src_e),
        .pc_target_e    (pc_target_e),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .pc_plus4_d     (pc_plus4_d),
        .valid_d        (valid_d),
        .rs1_d          (rs1_d),
        .rs2_d          (rs2_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_addr"},      imem_addr,           32'h0);
        chk({tag, "_instr"},     instr_d,             32'h0000_0013);
        chk({tag, "_pc_d"},      pc_d,                32'h0);
        chk({tag, "_pc4_d"},     pc_plus4_d,          32'h0);
        chk({tag, "_valid_d"},   32'(valid_d),        32'd0);
        chk({tag, "_rs1"},       32'(rs1_d),          32'd0);
        chk({tag, "_rs2"},       32'(rs2_d),          32'd0);
    endtask

    initial begin
        rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pc_src_e = 1'b0; pc_target_e = 32'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        #2;
        chk_reset_outputs("rst");

        // basic fetch with 1-cycle memory
        cyc(); cyc();
        rst = 1'b0; imem_req_ready = 1'b1; #1;
        chk("s1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("s1_addr0", imem_addr, 32'h0);
        cyc();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093; #1;
        chk("s1_wait_noreq", 32'(imem_req_valid), 32'd0);
        cyc();
        imem_rsp_valid = 1'b0; #1;
        chk("s1_instr0", instr_d, 32'h0050_0093);
        chk("s1_pc0", pc_d, 32'h0);
        chk("s1_pc4_0", pc_plus4_d, 32'h4);
        chk("s1_valid0", 32'(valid_d), 32'd1);
        chk("s1_rs1_0", 32'(rs1_d), 32'd0);
        chk("s1_rs2_0", 32'(rs2_d), 32'd5);
        chk("s1_addr4", imem_addr, 32'h4);
        cyc();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0113; #1;
        chk("s1_bubble", 32'(valid_d), 32'd0);
        chk("s1_bubble_nop", instr_d, 32'h0000_0013);
        cyc();
        imem_rsp_valid = 1'b0; #1;
        chk("s1_instr1", instr_d, 32'h0010_0113);
        chk("s1_pc1", pc_d, 32'h4);
        chk("s1_pc4_1", pc_plus4_d, 32'h8);
        chk("s1_valid1", 32'(valid_d), 32'd1);
        chk("s1_rs2_1", 32'(rs2_d), 32'd1);
        chk("s1_addr8", imem_addr, 32'h8);

        // stall_d for 3 cycles while the response arrives
        cyc();
        stall_d = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_8193; #1;
        cyc();
        imem_rsp_valid = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("s2_hold_noreq", 32'(imem_req_valid), 32'd0);
            chk("s2_hold_valid", 32'(valid_d), 32'd0);
            chk("s2_hold_pc", pc_d, 32'h4);
            if (i < 2) cyc();
        end
        stall_d = 1'b0;
        cyc();
        chk("s2_instr", instr_d, 32'h0020_8193);
        chk("s2_pc", pc_d, 32'h8);
        chk("s2_pc4", pc_plus4_d, 32'hC);
        chk("s2_valid", 32'(valid_d), 32'd1);
        chk("s2_rs1", 32'(rs1_d), 32'd1);
        chk("s2_addr", imem_addr, 32'hC);
        chk("s2_req", 32'(imem_req_valid), 32'd1);

        // redirect while WAIT: stale response dropped; target low bits ignored
        cyc();
        pc_src_e = 1'b1; pc_target_e = 32'h0000_0102; #1;
        cyc();
        pc_src_e = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; #1;
        cyc();
        imem_rsp_valid = 1'b0; #1;
        chk("s3_drop_valid", 32'(valid_d), 32'd0);
        chk("s3_drop_instr", instr_d, 32'h0000_0013);
        chk("s3_addr", imem_addr, 32'h100);
        chk("s3_req", 32'(imem_req_valid), 32'd1);
        cyc();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00A0_0513; #1;
        chk("s3_wait_valid", 32'(valid_d), 32'd0);
        cyc();
        imem_rsp_valid = 1'b0; #1;
        chk("s3_instr", instr_d, 32'h00A0_0513);
        chk("s3_pc", pc_d, 32'h100);
        chk("s3_pc4", pc_plus4_d, 32'h104);
        chk("s3_valid", 32'(valid_d), 32'd1);

        // flush_d + redirect in the response cycle
        cyc();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        flush_d = 1'b1; pc_src_e = 1'b1; pc_target_e = 32'h200; #1;
        cyc();
        imem_rsp_valid = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0; imem_req_ready = 1'b0; #1;
        chk("s4_instr", instr_d, 32'h0000_0013);
        chk("s4_valid", 32'(valid_d), 32'd0);
        chk("s4_pc_keep", pc_d, 32'h100);
        chk("s4_addr", imem_addr, 32'h200);
        chk("s4_req", 32'(imem_req_valid), 32'd1);

        // ready low 5 cycles, stall_f for 2 of them
        for (int i = 0; i < 5; i++) begin
            cyc();
            stall_f = (i == 1 || i == 2); #1;
            chk("s5_req_valid", 32'(imem_req_valid), (i == 1 || i == 2) ? 32'd0 : 32'd1);
            chk("s5_addr", imem_addr, 32'h200);
        end
        stall_f = 1'b0; imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0; #1;
        chk("s6_in_wait", 32'(imem_req_valid), 32'd0);

        // async reset while WAIT, then a late response
        rst = 1'b1; #1;
        chk_reset_outputs("s6_rst");
        #1;
        rst = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_F00D;
        cyc();
        imem_rsp_valid = 1'b0; #1;
        chk("s6_late_valid", 32'(valid_d), 32'd0);
        chk("s6_late_instr", instr_d, 32'h0000_0013);
        chk("s6_addr", imem_addr, 32'h0);
        chk("s6_req", 32'(imem_req_valid), 32'd1);
        imem_req_ready = 1'b1;
        cyc();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093; #1;
        cyc();
        imem_rsp_valid = 1'b0; #1;
        chk("s6_instr", instr_d, 32'h0050_0093);
        chk("s6_pc", pc_d, 32'h0);
        chk("s6_valid", 32'(valid_d), 32'd1);

        // PC wrap at the top of the address space
        imem_req_ready = 1'b0; pc_src_e = 1'b1; pc_target_e = 32'hFFFF_FFFF; #1;
        cyc();
        pc_src_e = 1'b0; imem_req_ready = 1'b1; #1;
        chk("s7_addr_top", imem_addr, 32'hFFFF_FFFC);
        cyc();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_8093; #1;
        cyc();
        imem_rsp_valid = 1'b0; #1;
        chk("s7_instr", instr_d, 32'h0010_8093);
        chk("s7_pc", pc_d, 32'hFFFF_FFFC);
        chk("s7_pc4_wrap", pc_plus4_d, 32'h0);
        chk("s7_addr_wrap", imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline. Owns the fetch PC, issues one outstanding request at a time to a variable-latency instruction memory over a valid/ready handshake, and drives the IF/ID pipeline register. It consumes `stall_f`, `stall_d`, `flush_d` and the execute-stage redirect (`pc_src_e`, `pc_target_e`), and produces the decode-stage fields the hazard unit compares, `rs1_d` and `rs2_d`.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `stall_f`  in  1  hold the PC and do not issue a new request.
- `stall_d`  in  1  hold the IF/ID register.
- `flush_d`  in  1  load a bubble into IF/ID.
- `pc_src_e`  in  1  redirect the fetch PC (taken branch or jump).
- `pc_target_e`  in  32  redirect address.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  32  request address, equal to `pc_f`.
- `imem_rsp_valid`  in  1  response valid, one cycle pulse per accepted request.
- `imem_rsp_data`  in  32  instruction word.
- `instr_d`  out  32  IF/ID instruction.
- `pc_d`  out  32  IF/ID PC.
- `pc_plus4_d`  out  32  IF/ID PC+4.
- `valid_d`  out  1  IF/ID holds a real instruction.
- `rs1_d`  out  5  `instr_d[19:15]`.
- `rs2_d`  out  5  `instr_d[24:20]`.

## Operation
- The FSM has three states:
  - REQ: `imem_req_valid = !stall_f`.
  - WAIT: one request is outstanding.
  - HOLD: a fetched word is parked in a one-entry buffer.
- Registered context (outstanding request): `req_pc` (address of the outstanding request) and `discard` (set when that request has been made stale by a redirect).
- REQ:
  - Handshake (`imem_req_valid && imem_req_ready`) → WAIT, with `req_pc <= pc_f`.
  - If `pc_src_e` is also high that cycle, set `discard`.
- WAIT, on `imem_rsp_valid`:
  - `discard` set → drop the word, clear `discard`, go to REQ.
  - Else if IF/ID can load (`!stall_d && !flush_d`) → IF/ID takes {word, `req_pc`, `req_pc+4`, 1}; `pc_f <= req_pc+4`; go to REQ.
  - Else → capture the word into the buffer and go to HOLD.
- HOLD:
  - When `!stall_d && !flush_d`, IF/ID loads from the buffer, `pc_f <= buffered pc+4`, go to REQ.
  - Otherwise stay in HOLD.
- Redirect (`pc_src_e`) has the highest priority:
  - `pc_f <= pc_target_e` in every state.
  - In WAIT, set `discard`.
  - In HOLD, drop the buffer and go to REQ.
  - A WAIT response that arrives in the same cycle as `pc_src_e` is dropped.
- IF/ID update priority:
  1. `flush_d` → bubble: `valid_d=0`, `instr_d=NOP` (32'h0000_0013); pc fields unchanged.
  2. `stall_d` → hold.
  3. Word available → load it.
  4. Otherwise → bubble.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Only word-aligned addresses are generated. `pc_target_e[1:0]` is ignored (forced to 0).

## Timing
- Reset values:
  - FSM state = REQ; `discard = 0`; `pc_f = RESET_PC`.
  - `imem_req_valid = 0` while `rst` is high.
  - `imem_addr = RESET_PC`.
  - `instr_d = 32'h0000_0013`, `pc_d = 0`, `pc_plus4_d = 0`, `valid_d = 0`.
  - `rs1_d = 0`, `rs2_d = 0`.
- Memory response arrives ≥1 cycle after the request handshake. A 1-cycle memory therefore gives 1 instruction per 2 cycles.
- Latency: the edge that samples `imem_rsp_valid` loads IF/ID. `instr_d` is visible in the cycle after the response.
- After a redirect, the first request to `pc_target_e` is issued in the next cycle that is in REQ.
- `rst` asserted mid-request: all state returns to its reset value asynchronously. A memory response arriving after `rst` deasserts without a new request is ignored, because the FSM is in REQ, not WAIT.
- `imem_req_valid`/`imem_addr` stay stable while waiting for `imem_req_ready`, except when `pc_src_e` changes the address or `stall_f` drops valid.

## Structure
- Shared package `riscv_pkg`:
  - `NOP_INSTR` = 32'h0000_0013.
  - Fetch-state enum {REQ, WAIT, HOLD}.
  - Register-field bit positions (`RS1_LSB` = 15, `RS2_LSB` = 20).
- One sub-module, `if_id_reg`: the IF/ID register implementing the flush > stall > load > bubble priority.
- The FSM, `pc_f`, `req_pc`, `discard` and the hold buffer stay in `fetch_stage`.

## Test plan
- Reset release, memory ready and 1-cycle response with words 0x00500093 then 0x00100113:
  - `imem_addr` = 0x0 then 0x4.
  - `instr_d` = 0x00500093 with `pc_d = 0`, `pc_plus4_d = 4`, `rs1_d = 0`.
  - `valid_d` alternates 1/0.
- `stall_d` held 3 cycles while a response arrives: FSM enters HOLD; IF/ID unchanged; the buffered word loads on the first cycle after `stall_d` falls, with no extra memory request.
- `pc_src_e = 1`, `pc_target_e = 0x100` while in WAIT: the response for the old PC is dropped; the next `imem_addr` is 0x100; `valid_d` stays 0 until the 0x100 word returns.
- `flush_d` and `pc_src_e` in the same cycle as a response: `instr_d = 0x00000013`, `valid_d = 0`, next request to `pc_target_e`.
- `imem_req_ready` held low 5 cycles: `imem_req_valid = 1` and `imem_addr` stable throughout; `stall_f = 1` for 2 of those cycles drops `imem_req_valid` to 0.
- `rst` pulsed while in WAIT, followed by a late `imem_rsp_valid`: outputs return to reset values; the late response is ignored; the first request after release goes to `RESET_PC`.
